// File: rtl/reg_file_2r1w.sv
// Two-read, one-write register file with byte and register-pair writes.
// Reads are registered and write-first: same-edge writes bypass to the outputs.
module reg_file_2r1w #(
    parameter int DATA_W = 8,
    parameter int NUM_REGS = 8,
    localparam int ADDR_W = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                re,
    input  logic [ADDR_W-1:0]   rs1_addr,
    input  logic [ADDR_W-1:0]   rs2_addr,
    input  logic                we,
    input  logic                wide,
    input  logic [ADDR_W-1:0]   rd_addr,
    input  logic [2*DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0]   rs1_data,
    output logic [DATA_W-1:0]   rs2_data,
    output logic                wr_err
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [DATA_W-1:0] nxt  [NUM_REGS];
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
    logic [ADDR_W-1:0] lo_addr;
    logic              pair_bad;
    logic              wr_ok;

    assign hi       = rd_data[2*DATA_W-1:DATA_W];
    assign lo       = rd_data[DATA_W-1:0];
    assign lo_addr  = rd_addr + ADDR_W'(1);
    assign pair_bad = we & wide & (rd_addr == LAST);
    assign wr_ok    = we & ~pair_bad;

    // Post-write view of the file; reads index it so bypass falls out per register.
    always_comb begin
        nxt = regs;
        if (wr_ok) begin
            if (wide) begin
                nxt[rd_addr] = hi;
                nxt[lo_addr] = lo;
            end else begin
                nxt[rd_addr] = lo;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            rs1_data <= '0;
            rs2_data <= '0;
            wr_err   <= 1'b0;
        end else begin
            regs   <= nxt;
            wr_err <= pair_bad;
            if (re) begin
                rs1_data <= nxt[rs1_addr];
                rs2_data <= nxt[rs2_addr];
            end
        end
    end

endmodule
